// File: rtl/mcp_snake_ctrl.sv
// Launch/capture sequencer for a register -> 3-stage AND chain -> register multicycle path.
// One transaction in flight: launch regs are held stable until the result is captured and handed off.
module mcp_snake_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MCP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned CW = ($clog2(MCP_CYCLES + 1) < 1) ? 1 : $clog2(MCP_CYCLES + 1);
  localparam logic [CW-1:0] CntInit = CW'(MCP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] la, lb, lc, ld;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [CW-1:0]    cnt;

  // The multicycle chain: only valid to sample MCP_CYCLES clocks after la..ld last changed.
  assign s1 = la & lb;
  assign s2 = s1 & lc;
  assign s3 = s2 & ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      la        <= '0;
      lb        <= '0;
      lc        <= '0;
      ld        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            la       <= in_a;
            lb       <= in_b;
            lc       <= in_c;
            ld       <= in_d;
            cnt      <= CntInit;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StWait;
          end
        end
        StWait: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_data  <= s3;
            out_valid <= 1'b1;
            state     <= StHold;
          end
        end
        StHold: begin
          // A pending in_valid is deliberately not accepted here; it is taken in IDLE next clock.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_snake_ctrl.sv
// Bench for mcp_snake_ctrl: two instances (MCP_CYCLES=2 and 1) checked every cycle against a
// transaction-level timing model, plus directed scenarios and a randomized soak.
module tb_mcp_snake_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c, d;
  logic         iv   [2];
  logic         ordy [2];
  logic         ir   [2];
  logic         ov   [2];
  logic         bs   [2];
  logic [W-1:0] od   [2];

  mcp_snake_ctrl #(.WIDTH(W), .MCP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(a), .in_b(b), .in_c(c), .in_d(d),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bs[0])
  );

  mcp_snake_ctrl #(.WIDTH(W), .MCP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(a), .in_b(b), .in_c(c), .in_d(d),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bs[1])
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mcp [2]  = '{2, 1};

  // Model: a transaction is "in flight" from accept until its output handshake; the result
  // appears exactly mcp clocks after the accept edge.
  bit           m_idle   [2];
  bit           m_valid  [2];
  int           m_launch [2];
  logic [W-1:0] m_exp    [2];
  logic [W-1:0] m_data   [2];
  bit           prev_ov  [2];
  int           rise_q0  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i]   = 1'b1;
      m_valid[i]  = 1'b0;
      m_launch[i] = 0;
      m_exp[i]    = '0;
      m_data[i]   = '0;
      prev_ov[i]  = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.in_ready", tag, i), 32'(ir[i]), 32'(m_idle[i]));
      chk($sformatf("%s.u%0d.busy", tag, i), 32'(bs[i]), 32'(!m_idle[i]));
      chk($sformatf("%s.u%0d.out_valid", tag, i), 32'(ov[i]), 32'(m_valid[i]));
      chk($sformatf("%s.u%0d.out_data", tag, i), 32'(od[i]), 32'(m_data[i]));
    end
  endtask

  // One clock: update the model from the inputs present at the edge, then check #1 later.
  task automatic step(input string tag);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_idle[i] && iv[i]) begin
        m_idle[i]   = 1'b0;
        m_launch[i] = cyc;
        m_exp[i]    = a & b & c & d;
      end else if (!m_idle[i] && !m_valid[i] && (cyc - m_launch[i] == mcp[i])) begin
        m_valid[i] = 1'b1;
        m_data[i]  = m_exp[i];
      end else if (m_valid[i] && ordy[i]) begin
        m_valid[i] = 1'b0;
        m_idle[i]  = 1'b1;
      end
    end
    #1;
    if (ov[0] === 1'b1 && !prev_ov[0]) rise_q0.push_back(cyc);
    for (int i = 0; i < 2; i++) prev_ov[i] = (ov[i] === 1'b1);
    check_all(tag);
  endtask

  task automatic set_ops(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [W-1:0] vd);
    a = va; b = vb; c = vc; d = vd;
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] sets [3][4];
    int           j;
    int           bound;

    // T1: reset asserted before any clock edge
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    set_ops(8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    #3;
    check_all("t1_reset");
    @(negedge clk);
    rst = 1'b0;
    step("t1_idle");

    // T2: MCP=2 basic transaction
    set_ops(8'hF0, 8'hFF, 8'h3C, 8'hFF);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    step("t2_acc");
    iv[0] = 1'b0;
    step("t2_k1");
    chk("t2_not_yet_valid", 32'(ov[0]), 32'd0);
    step("t2_k2");
    chk("t2_valid_k2", 32'(ov[0]), 32'd1);
    chk("t2_data_30", 32'(od[0]), 32'h30);
    step("t2_k3");
    chk("t2_ready_k3", 32'(ir[0]), 32'd1);

    // T3: MCP=1 instance
    set_ops(8'hAA, 8'h0F, 8'hFF, 8'hFF);
    iv[1] = 1'b1; ordy[1] = 1'b1;
    step("t3_acc");
    iv[1] = 1'b0;
    step("t3_k1");
    chk("t3_valid_k1", 32'(ov[1]), 32'd1);
    chk("t3_data_0a", 32'(od[1]), 32'h0A);
    step("t3_k2");

    // T4: backpressure while in_a toggles
    set_ops(8'h5A, 8'hF3, 8'h7E, 8'hCF);
    iv[0] = 1'b1; ordy[0] = 1'b0;
    step("t4_acc");
    iv[0] = 1'b0;
    step("t4_k1");
    step("t4_k2");
    held = od[0];
    chk("t4_data", 32'(held), 32'(8'h5A & 8'hF3 & 8'h7E & 8'hCF));
    for (int k = 0; k < 5; k++) begin
      a = ~a;
      iv[0] = 1'b1;
      step("t4_hold");
      chk("t4_data_stable", 32'(od[0]), 32'(held));
      chk("t4_in_ready_low", 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    step("t4_release");
    chk("t4_back_idle", 32'(ir[0]), 32'd1);

    // T5: back-to-back, in_valid held high over three sets
    sets[0] = '{8'hFF, 8'h81, 8'hC3, 8'hE7};
    sets[1] = '{8'h12, 8'h36, 8'h7F, 8'hFE};
    sets[2] = '{8'hF8, 8'h9F, 8'hFF, 8'hBD};
    rise_q0.delete();
    j = 0;
    set_ops(sets[0][0], sets[0][1], sets[0][2], sets[0][3]);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    bound = 0;
    while (rise_q0.size() < 3 && bound < 40) begin
      step("t5");
      bound++;
      if (m_launch[0] == cyc) begin
        j++;
        if (j < 3) set_ops(sets[j][0], sets[j][1], sets[j][2], sets[j][3]);
        else iv[0] = 1'b0;
      end
    end
    chk("t5_results", 32'(rise_q0.size()), 32'd3);
    if (rise_q0.size() == 3) begin
      chk("t5_gap1", 32'(rise_q0[1] - rise_q0[0]), 32'd4);
      chk("t5_gap2", 32'(rise_q0[2] - rise_q0[1]), 32'd4);
    end
    step("t5_drain");
    step("t5_drain");

    // T6: reset while in WAIT with cnt at zero
    set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    step("t6_acc");
    iv[0] = 1'b0;
    step("t6_k1");
    rst = 1'b1;
    model_reset();
    #1;
    check_all("t6_rst");
    #1;
    rst = 1'b0;
    step("t6_no_pulse");
    chk("t6_no_valid", 32'(ov[0]), 32'd0);
    set_ops(8'h3C, 8'h0F, 8'hFF, 8'h77);
    iv[0] = 1'b1;
    step("t6_acc2");
    iv[0] = 1'b0;
    step("t6_k1b");
    step("t6_k2b");
    chk("t6_own_result", 32'(od[0]), 32'(8'h3C & 8'h0F & 8'hFF & 8'h77));
    step("t6_done");

    // Randomized soak on both instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      set_ops(W'($urandom | $urandom), W'($urandom | $urandom),
              W'($urandom | $urandom), W'($urandom | $urandom));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
